// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Line geometry defaults match the cmu that drives each master port.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int CMU_LINE_WORDS       = 4;
  localparam int CMU_LINE_WORDS_WIDTH = 2;

endpackage

// File: rtl/mem_arbiter_rr.sv
// arb_rr2: two-requester round-robin picker.
// On a tie the master that was not served last wins.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  // pick the winner; a lone requester always wins
  always_comb begin
    winner = M0;
    unique case (1'b1)
      req0 && req1:  winner = (last == M0) ? M1 : M0;
      !req0 && req1: winner = M1;
      default:       winner = M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-side and D-side cmu.
// Optional watchdog release enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS       = CMU_LINE_WORDS,
  parameter int LINE_WORDS_WIDTH = CMU_LINE_WORDS_WIDTH,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cs_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic        m1_cs_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  state_t state;
  logic [LINE_WORDS_WIDTH-1:0] beat_cnt;
  logic last;
  logic win;
  logic own0, own1;
  logic own_cs;
  logic beat_last;
  logic rel;
  logic tmo_fire;

  arb_rr2 u_rr (
    .req0   (m0_cs_i),
    .req1   (m1_cs_i),
    .last   (last),
    .winner (win)
  );

  assign own0    = (state == S_GNT0);
  assign own1    = (state == S_GNT1);
  assign grant_o = {own1, own0};

  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;
  assign m0_ack_o  = own0 & (mem_ack_i | tmo_fire);
  assign m1_ack_o  = own1 & (mem_ack_i | tmo_fire);

  assign own_cs    = own1 ? m1_cs_i : m0_cs_i;
  assign beat_last = mem_ack_i &&
    (beat_cnt == LINE_WORDS_WIDTH'(LINE_WORDS - 1));
  assign rel = (own0 | own1) &&
    (!own_cs || beat_last || tmo_fire);

  // route the owner's request onto the memory port
  always_comb begin
    mem_cs_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    unique case (1'b1)
      own0: begin
        mem_cs_o   = m0_cs_i;
        mem_we_o   = m0_we_i;
        mem_addr_o = m0_addr_i;
        mem_data_o = m0_data_i;
      end
      own1: begin
        mem_cs_o   = m1_cs_i;
        mem_we_o   = m1_we_i;
        mem_addr_o = m1_addr_i;
        mem_data_o = m1_data_i;
      end
      default: ;
    endcase
  end

  // grant FSM: hold owner for a full line, idle one cycle per release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      last     <= M1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (m0_cs_i || m1_cs_i)
            state <= (win == M1) ? S_GNT1 : S_GNT0;
        end
        default: begin
          if (rel) begin
            state    <= S_IDLE;
            last     <= own1 ? M1 : M0;
            beat_cnt <= '0;
          end else if (mem_ack_i) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic tmo_flag;
  logic stall;

  assign stall = (own0 | own1) && mem_cs_o && !mem_ack_i;
  assign tmo_fire = stall &&
    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = tmo_flag;

  // count consecutive unacked cycles; fire forces a release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (tmo_fire)
        tmo_flag <= 1'b1;
      if (!stall || tmo_fire)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic tmo_unused;

  assign tmo_unused = (TIMEOUT_CYCLES != 0);
  assign tmo_fire   = 1'b0;
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle tables per scenario.
// Master and memory responders are simple cmu/memory stand-ins.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cs_i, m0_we_i, m0_ack_o;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic        m1_cs_i, m1_we_i, m1_ack_o;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        mem_cs_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_cs_i    (m0_cs_i),
    .m0_we_i    (m0_we_i),
    .m0_addr_i  (m0_addr_i),
    .m0_data_i  (m0_data_i),
    .m0_data_o  (m0_data_o),
    .m0_ack_o   (m0_ack_o),
    .m1_cs_i    (m1_cs_i),
    .m1_we_i    (m1_we_i),
    .m1_addr_i  (m1_addr_i),
    .m1_data_i  (m1_data_i),
    .m1_data_o  (m1_data_o),
    .m1_ack_o   (m1_ack_o),
    .mem_cs_o   (mem_cs_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i),
    .grant_o    (grant_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int ncyc = 0;
  int m0_left, m1_left;
  logic m1_fill_pend, m1_gap;
  logic [31:0] m1_fill_addr;
  logic a0, a1, cs_prev, ack_prev, mem_en;
  logic [37:0] exq[$];

  function automatic logic [37:0] E(input logic [1:0] g,
    input logic k0, input logic k1, input logic we,
    input logic [31:0] ad);
    return {g, k0, k1, |g, we, ad};
  endfunction

  function automatic logic [37:0] obs();
    return {grant_o, m0_ack_o, m1_ack_o,
            mem_cs_o, mem_we_o, mem_addr_o};
  endfunction

  task automatic push_burst(input logic m, input logic we,
    input logic [31:0] base);
    logic [1:0] g;
    g = m ? 2'b10 : 2'b01;
    for (int b = 0; b < 4; b++) begin
      exq.push_back(E(g, 1'b0, 1'b0, we, base + 32'(4 * b)));
      exq.push_back(E(g, ~m, m, we, base + 32'(4 * b)));
    end
  endtask

  task automatic push_idle();
    exq.push_back(E(2'b00, 1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  task automatic start_m0(input logic we, input logic [31:0] ad);
    m0_cs_i = 1'b1;
    m0_we_i = we;
    m0_addr_i = ad;
    m0_data_i = 32'hA000_0000;
    m0_left = 4;
  endtask

  task automatic start_m1(input logic we, input logic [31:0] ad);
    m1_cs_i = 1'b1;
    m1_we_i = we;
    m1_addr_i = ad;
    m1_data_i = 32'h5000_0000;
    m1_left = 4;
  endtask

  // one clock: advance masters on last cycle's acks, then memory
  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
    if (m1_gap) begin
      m1_gap = 1'b0;
      m1_cs_i = 1'b1;
      m1_we_i = 1'b0;
      m1_addr_i = m1_fill_addr;
      m1_left = 4;
    end else if (a1 && m1_left > 0) begin
      m1_left--;
      m1_addr_i += 32'd4;
      m1_data_i += 32'd1;
      if (m1_left == 0) begin
        m1_cs_i = 1'b0;
        if (m1_fill_pend) begin
          m1_fill_pend = 1'b0;
          m1_gap = 1'b1;
        end
      end
    end
    if (a0 && m0_left > 0) begin
      m0_left--;
      m0_addr_i += 32'd4;
      m0_data_i += 32'd1;
      if (m0_left == 0) m0_cs_i = 1'b0;
    end
    mem_ack_i = mem_en && cs_prev && !ack_prev;
    mem_data_i = 32'hD000_0000 + 32'(ncyc);
    #1;
    a0 = m0_ack_o;
    a1 = m1_ack_o;
    cs_prev = mem_cs_o;
    ack_prev = mem_ack_i;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m0_cs_i = 1'b0; m0_we_i = 1'b0;
    m0_addr_i = '0; m0_data_i = '0;
    m1_cs_i = 1'b0; m1_we_i = 1'b0;
    m1_addr_i = '0; m1_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    m0_left = 0; m1_left = 0;
    m1_fill_pend = 1'b0; m1_gap = 1'b0;
    m1_fill_addr = '0;
    a0 = 1'b0; a1 = 1'b0;
    cs_prev = 1'b0; ack_prev = 1'b0;
    mem_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m0_cs_i = 1'b1;
    m1_cs_i = 1'b1;
    mem_ack_i = 1'b1;
    @(posedge clk);
    #2;
    nvec++;
    if (grant_o !== 2'b00) begin
      nerr++;
      $display("FAIL reset_grant: got %b want 00", grant_o);
    end
    nvec++;
    if ({mem_cs_o, mem_we_o} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_cs_we: got %b want 00",
               {mem_cs_o, mem_we_o});
    end
    nvec++;
    if (mem_addr_o !== 32'h0) begin
      nerr++;
      $display("FAIL reset_addr: got %h want 0", mem_addr_o);
    end
    nvec++;
    if ({m0_ack_o, m1_ack_o} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_acks: got %b want 00",
               {m0_ack_o, m1_ack_o});
    end
    nvec++;
    if (timeout_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_timeout: got %b want 0", timeout_o);
    end
    m0_cs_i = 1'b0;
    m1_cs_i = 1'b0;
    mem_ack_i = 1'b0;
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_contention();
    exq = {};
    push_burst(1'b0, 1'b0, 32'h100);
    push_idle();
    push_burst(1'b1, 1'b0, 32'h200);
    push_idle();
    start_m0(1'b0, 32'h100);
    start_m1(1'b0, 32'h200);
    for (int i = 0; i < exq.size(); i++) begin
      cyc();
      nvec++;
      if (obs() !== exq[i]) begin
        nerr++;
        $display("FAIL contention c%0d: got %h want %h",
                 i + 1, obs(), exq[i]);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] dexp;
    exq = {};
    push_burst(1'b0, 1'b0, 32'h100);
    push_idle();
    start_m0(1'b0, 32'h100);
    for (int i = 0; i < exq.size(); i++) begin
      cyc();
      nvec++;
      if (obs() !== exq[i]) begin
        nerr++;
        $display("FAIL single c%0d: got %h want %h",
                 i + 1, obs(), exq[i]);
      end
      dexp = 32'hD000_0000 + 32'(ncyc);
      nvec++;
      if ({m0_data_o, m1_data_o} !== {dexp, dexp}) begin
        nerr++;
        $display("FAIL single_rdata c%0d: got %h/%h want %h",
                 i + 1, m0_data_o, m1_data_o, dexp);
      end
    end
  endtask

  task automatic test_mid_burst();
    exq = {};
    push_burst(1'b0, 1'b0, 32'h500);
    push_idle();
    push_burst(1'b1, 1'b0, 32'h600);
    push_idle();
    start_m0(1'b0, 32'h500);
    for (int i = 0; i < exq.size(); i++) begin
      cyc();
      nvec++;
      if (obs() !== exq[i]) begin
        nerr++;
        $display("FAIL mid_burst c%0d: got %h want %h",
                 i + 1, obs(), exq[i]);
      end
      if (i == 2) start_m1(1'b0, 32'h600);
    end
  endtask

  task automatic test_wb_fill();
    exq = {};
    push_burst(1'b1, 1'b1, 32'h2000);
    push_idle();
    push_burst(1'b0, 1'b0, 32'h400);
    push_idle();
    push_burst(1'b1, 1'b0, 32'h3000);
    push_idle();
    start_m1(1'b1, 32'h2000);
    m1_fill_pend = 1'b1;
    m1_fill_addr = 32'h3000;
    for (int i = 0; i < exq.size(); i++) begin
      cyc();
      nvec++;
      if (obs() !== exq[i]) begin
        nerr++;
        $display("FAIL wb_fill c%0d: got %h want %h",
                 i + 1, obs(), exq[i]);
      end
      if (i < 8) begin
        nvec++;
        if (mem_data_o !== 32'h5000_0000 + 32'(i / 2)) begin
          nerr++;
          $display("FAIL wb_wdata c%0d: got %h want %h", i + 1,
                   mem_data_o, 32'h5000_0000 + 32'(i / 2));
        end
      end
      if (i == 1) start_m0(1'b0, 32'h400);
    end
  endtask

  task automatic test_reset_mid_burst();
    exq = {};
    exq.push_back(E(2'b01, 1'b0, 1'b0, 1'b0, 32'h700));
    exq.push_back(E(2'b01, 1'b1, 1'b0, 1'b0, 32'h700));
    exq.push_back(E(2'b01, 1'b0, 1'b0, 1'b0, 32'h704));
    start_m0(1'b0, 32'h700);
    for (int i = 0; i < exq.size(); i++) begin
      cyc();
      nvec++;
      if (obs() !== exq[i]) begin
        nerr++;
        $display("FAIL rst_pre c%0d: got %h want %h",
                 i + 1, obs(), exq[i]);
      end
    end
    rst = 1'b0;
    #1;
    nvec++;
    if ({grant_o, mem_cs_o} !== 3'b000) begin
      nerr++;
      $display("FAIL rst_async: grant %b cs %b want 00 0",
               grant_o, mem_cs_o);
    end
    m0_cs_i = 1'b0;
    m0_left = 0;
    mem_ack_i = 1'b0;
    a0 = 1'b0; a1 = 1'b0;
    cs_prev = 1'b0; ack_prev = 1'b0;
    cyc();
    nvec++;
    if (obs() !== E(2'b00, 1'b0, 1'b0, 1'b0, 32'h0)) begin
      nerr++;
      $display("FAIL rst_hold: got %h want idle", obs());
    end
    rst = 1'b1;
    exq = {};
    push_burst(1'b1, 1'b0, 32'h800);
    push_idle();
    start_m1(1'b0, 32'h800);
    for (int i = 0; i < exq.size(); i++) begin
      cyc();
      nvec++;
      if (obs() !== exq[i]) begin
        nerr++;
        $display("FAIL rst_post c%0d: got %h want %h",
                 i + 1, obs(), exq[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [37:0] ev[];
    logic tv[];
`ifdef ARB_TIMEOUT_EN
    ev = new[10];
    tv = new[10];
    for (int i = 0; i < 7; i++) begin
      ev[i] = E(2'b01, 1'b0, 1'b0, 1'b0, 32'h900);
      tv[i] = 1'b0;
    end
    ev[7] = E(2'b01, 1'b1, 1'b0, 1'b0, 32'h900);
    tv[7] = 1'b0;
    ev[8] = E(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    tv[8] = 1'b1;
    ev[9] = E(2'b01, 1'b0, 1'b0, 1'b0, 32'h904);
    tv[9] = 1'b1;
`else
    ev = new[12];
    tv = new[12];
    for (int i = 0; i < 12; i++) begin
      ev[i] = E(2'b01, 1'b0, 1'b0, 1'b0, 32'h900);
      tv[i] = 1'b0;
    end
`endif
    mem_en = 1'b0;
    start_m0(1'b0, 32'h900);
    for (int i = 0; i < ev.size(); i++) begin
      cyc();
      nvec++;
      if ({obs(), timeout_o} !== {ev[i], tv[i]}) begin
        nerr++;
        $display("FAIL timeout c%0d: got %h/%b want %h/%b",
                 i + 1, obs(), timeout_o, ev[i], tv[i]);
      end
    end
    m0_cs_i = 1'b0;
    m0_left = 0;
    mem_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      nvec++;
      if ({grant_o, timeout_o} !== {2'b00, tv[ev.size() - 1]}) begin
        nerr++;
        $display("FAIL timeout_after c%0d: got %b/%b want 00/%b",
                 i + 1, grant_o, timeout_o, tv[ev.size() - 1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_mid_burst();
    test_wb_fill();
    test_reset_mid_burst();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory port between two cmu instances: master 0 is the instruction-side cmu, master 1 the data-side cmu.
- Each master uses the cmu memory handshake (cs/we/addr/data/ack) and issues line bursts of LINE_WORDS beats.
- The arbiter grants one master at a time and holds the grant for a whole burst; no beat of a line is ever interleaved with another master.
- Sits between the two cmu blocks and the memory model/bus.

Parameters:
- LINE_WORDS, 4, beats per line burst; must match cmu LINE_WORDS.
- LINE_WORDS_WIDTH, 2, log2(LINE_WORDS); width of the beat counter.
- TIMEOUT_CYCLES, 255, cycles without mem_ack_i before a timeout fires (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_cs_i  in  1  master 0 request (chip select).
- m0_we_i  in  1  master 0 write enable.
- m0_addr_i  in  32  master 0 address.
- m0_data_i  in  32  master 0 write data.
- m0_data_o  out  32  read data to master 0.
- m0_ack_o  out  1  beat acknowledge to master 0.
- m1_cs_i, m1_we_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: same as master 0, for master 1.
- mem_cs_o  out  1  memory chip select.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  memory address.
- mem_data_o  out  32  memory write data.
- mem_data_i  in  32  memory read data.
- mem_ack_i  in  1  memory beat acknowledge.
- grant_o  out  2  one-hot current owner; 00 = none.
- timeout_o  out  1  sticky timeout flag; tied 0 when ARB_TIMEOUT_EN is not defined.

Behaviour:
- States: S_IDLE, S_GNT0, S_GNT1.
- Registers: state, beat_cnt[LINE_WORDS_WIDTH-1:0], last (id of the last master served).
- Reset (rst=0, asynchronous): state=S_IDLE, beat_cnt=0, last=1 (so master 0 wins first), timeout_o=0.
- In S_IDLE: all mem_* outputs 0, both acks 0, grant_o=00.
- S_IDLE transitions:
  - only m0_cs_i high -> S_GNT0.
  - only m1_cs_i high -> S_GNT1.
  - both high -> grant the master != last (round-robin).
  - Grant is registered: memory sees the request one cycle after the master's cs rises (1-cycle arbitration latency).
- S_GNTn, datapath:
  - mem_cs_o/we/addr/data_o are driven combinationally from master n.
  - mn_ack_o = mem_ack_i.
  - Non-owner ack is 0.
  - m0_data_o = m1_data_o = mem_data_i at all times; only the owner's ack qualifies it.
- S_GNTn, beat counting: each mem_ack_i increments beat_cnt; it wraps to 0 after LINE_WORDS-1.
- S_GNTn, release (next state is S_IDLE, last<=n, beat_cnt<=0) on either condition:
  - (a) mem_ack_i with beat_cnt==LINE_WORDS-1 (burst complete), or
  - (b) mn_cs_i low (master abandoned, or write-back-to-fill gap).
- A release always passes through one S_IDLE cycle. The cmu's one-cycle cs-low gap between write-back and fill therefore lets the other master win if it is waiting.
- A request from the non-owner is ignored until release; that master stays stalled with ack 0.
- mem_ack_i while in S_IDLE is ignored (not routed to either master).
- Reset mid-burst: the grant drops immediately and mem_cs_o goes to 0 in the same cycle, asynchronously.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive S_GNTn cycles with mem_cs_o=1 and mem_ack_i=0; any ack clears it.
  - When the counter reaches TIMEOUT_CYCLES: timeout_o<=1 (sticky until reset), force release to S_IDLE, and pulse mn_ack_o for one cycle so the cmu FSM advances instead of hanging.
- Not defined: no counter, timeout_o tied 0, grants can be held indefinitely.

Decomposition:
- Shared package: state encodings S_IDLE/S_GNT0/S_GNT1, master-id constants M0=0/M1=1, LINE_WORDS and LINE_WORDS_WIDTH defaults shared with cmu.
- One natural sub-module: arb_rr2, a two-requester round-robin picker (inputs req0, req1, last; output winner id).
- The output mux and beat counter stay in mem_arbiter.

Test Plan:
- Single master: m0 reads a 4-beat line at 0x100 with 1-cycle memory latency -> mem_addr_o 0x100, 0x104, 0x108, 0x10C; four m0_ack_o pulses; m1_ack_o never asserted; grant_o 01 then 00.
- Contention: m0_cs_i and m1_cs_i rise in the same cycle after reset -> m0 served first (last=1). After the 4th ack there is one S_IDLE cycle, then grant_o=10 and m1's addresses appear.
- Mid-burst request: m1 raises cs during m0's beat 2 -> m1_ack_o stays 0 until m0's 4th ack; no m1 address appears on mem_addr_o before then.
- Write-back then fill: m1 writes back at 0x2000 (we=1, 4 beats), drops cs one cycle, then fills while m0 is waiting -> m0's burst runs between m1's write-back and fill; mem_we_o is 1 only for m1's write beats.
- Reset mid-burst: assert rst low after beat 1 -> mem_cs_o=0 and grant_o=00 immediately. After release, a new m1 request is granted before m0 (last=1 reset value, m0 not requesting).
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: memory never acks -> after 8 cycles timeout_o=1, one m0_ack_o pulse, state returns to S_IDLE, timeout_o remains 1.
